input_conditioner: RTL



---
 rtl/input_conditioner_if.sv | 20 ++
 rtl/input_conditioner.sv | 119 +++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Board-input bundle between the raw button/switch pins and the conditioned levels.
// Raw side: BTN_y[3:0] and SW[15:0] from the board. Clean side: BTN_OK, SW_OK, BTN_pulse.
// master drives the raw levels and observes the clean outputs; slave is the conditioner.
interface input_conditioner_if;
  logic [3:0]  BTN_y;
  logic [15:0] SW;
  logic [3:0]  BTN_OK;
  logic [15:0] SW_OK;
  logic [3:0]  BTN_pulse;

  modport master (
    output BTN_y, SW,
    input  BTN_OK, SW_OK, BTN_pulse
  );

  modport slave (
    input  BTN_y, SW,
    output BTN_OK, SW_OK, BTN_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: synchronise + debounce 4 buttons and 16 switches, emit button rising-edge pulses
//          and a held, synchronously released active-high system reset.
// Latency: 2-flop sync, then STABLE_TICKS prescaler ticks to flip; no backpressure (free-running).
// Ports: clk, RSTN (async active-low board reset), io (slave: BTN_y/SW in, BTN_OK/SW_OK/BTN_pulse out),
//        rst (active-high, asserts asynchronously, released RST_HOLD edges after RSTN rises).
module input_conditioner #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 8,
  parameter int RST_HOLD     = 16
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input_conditioner_if.slave   io,
  output logic                 rst
);

  localparam int NB = 20;
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_END  = HW'(RST_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  // Bits 15:0 are switches, bits 19:16 are buttons.
  logic [NB-1:0] raw;
  logic [NB-1:0] sync_a;
  logic [NB-1:0] sync_b;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_nxt;
  logic [CW-1:0] cnt     [NB];
  logic [CW-1:0] cnt_nxt [NB];
  logic [PW-1:0] pre;
  logic          tick;
  logic [3:0]    pulse;
  logic [HW-1:0] hold;

  assign raw = {io.BTN_y, io.SW};

  // Two-flop synchroniser; only sync_b feeds the debouncers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Sample-rate prescaler: tick marks the last count of each period.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == PRE_LAST);

  // Per-bit debounce: count consecutive ticks that disagree with the current
  // level; one agreeing tick restarts the count.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < NB; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (sync_b[i] == deb[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = sync_b[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulse is registered alongside the level so it lines up with the first
  // cycle BTN_OK reads high.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      deb   <= '0;
      pulse <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb   <= deb_nxt;
      pulse <= deb_nxt[19:16] & ~deb[19:16];
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign io.SW_OK     = deb[15:0];
  assign io.BTN_OK    = deb[19:16];
  assign io.BTN_pulse = pulse;

  // Reset stretcher: hold saturates at RST_HOLD; rst drops on the edge that
  // moves it there.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      hold <= '0;
      rst  <= 1'b1;
    end else if (hold != HOLD_END) begin
      hold <= hold + 1'b1;
      rst  <= (hold != HOLD_LAST);
    end
  end

endmodule
